// File: rtl/sa_pkg.sv
// Shared types and tile packing helpers for the systolic-array tile loader.
// Element indices map (row, k) and (k, col) onto the flat 8-entry tile buses.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        OUT,
        ERR
    } state_t;

    localparam int TILE_N = 8;
    localparam int TO_W   = 4;

    function automatic logic [2:0] a_idx(input logic r, input logic [1:0] k);
        return {r, k};
    endfunction

    function automatic logic [2:0] b_idx(input logic [1:0] k, input logic c);
        return {c, k};
    endfunction

endpackage

// File: rtl/sa_tile_loader_if.sv
// Bundle of the loader's request, buffer read, array and result ports.
// master is the loader side, slave is the surrounding environment.
interface sa_tile_loader_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
);

    logic                start;
    logic                start_ready;
    logic [ADDR_W-1:0]   a_base;
    logic [ADDR_W-1:0]   a_stride;
    logic [ADDR_W-1:0]   b_base;
    logic [ADDR_W-1:0]   b_stride;
    logic                cal_imp_in;
    logic                a_rd_en;
    logic [ADDR_W-1:0]   a_rd_addr;
    logic [WIDTH-1:0]    a_rd_data;
    logic                b_rd_en;
    logic [ADDR_W-1:0]   b_rd_addr;
    logic [WIDTH-1:0]    b_rd_data;
    logic [8*WIDTH-1:0]  sa_a;
    logic [8*WIDTH-1:0]  sa_b;
    logic                sa_enable;
    logic                sa_cal_imp;
    logic                sa_done;
    logic [8*WIDTH-1:0]  sa_result;
    logic                out_valid;
    logic                out_ready;
    logic [8*WIDTH-1:0]  out_tile;
    logic                err;

    modport master (
        input  start, a_base, a_stride, b_base, b_stride, cal_imp_in,
        input  a_rd_data, b_rd_data, sa_done, sa_result, out_ready,
        output start_ready, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output sa_a, sa_b, sa_enable, sa_cal_imp, out_valid, out_tile, err
    );

    modport slave (
        output start, a_base, a_stride, b_base, b_stride, cal_imp_in,
        output a_rd_data, b_rd_data, sa_done, sa_result, out_ready,
        input  start_ready, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  sa_a, sa_b, sa_enable, sa_cal_imp, out_valid, out_tile, err
    );

endinterface

// File: rtl/sa_addr_gen.sv
// Read address generation for one load step: A walks a row, B gathers a column.
// All sums wrap modulo 2^ADDR_W.
module sa_addr_gen
    import sa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [$clog2(TILE_N)-1:0] cnt,
    input  logic [ADDR_W-1:0]         a_base,
    input  logic [ADDR_W-1:0]         a_stride,
    input  logic [ADDR_W-1:0]         b_base,
    input  logic [ADDR_W-1:0]         b_stride,
    output logic [ADDR_W-1:0]         a_addr,
    output logic [ADDR_W-1:0]         b_addr
);

    logic [ADDR_W-1:0] a_row;
    logic [ADDR_W-1:0] b_row;

    assign a_row  = cnt[2] ? a_stride : '0;
    assign b_row  = ADDR_W'(cnt[1:0]) * b_stride;
    assign a_addr = a_base + a_row + ADDR_W'(cnt[1:0]);
    assign b_addr = b_base + b_row + ADDR_W'(cnt[2]);

endmodule

// File: rtl/sa_tile_loader.sv
// Fetches A/B tiles, drives the systolic array until done, and hands the
// result tile downstream; a watchdog parks the loader in ERR if done never comes.
module sa_tile_loader
    import sa_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              _reset,
    sa_tile_loader_if.master  bus
);

    state_t              state;
    state_t              nxt;
    logic [3:0]          cnt;
    logic [TO_W-1:0]     wd;
    logic [ADDR_W-1:0]   a_base_q;
    logic [ADDR_W-1:0]   a_stride_q;
    logic [ADDR_W-1:0]   b_base_q;
    logic [ADDR_W-1:0]   b_stride_q;
    logic                cal_q;
    logic [8*WIDTH-1:0]  a_q;
    logic [8*WIDTH-1:0]  b_q;
    logic [8*WIDTH-1:0]  tile_q;
    logic [ADDR_W-1:0]   a_addr;
    logic [ADDR_W-1:0]   b_addr;
    logic                rd;
    logic [2:0]          wr_n;
    logic [2:0]          wr_a;
    logic [2:0]          wr_b;

    sa_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .cnt      (cnt[2:0]),
        .a_base   (a_base_q),
        .a_stride (a_stride_q),
        .b_base   (b_base_q),
        .b_stride (b_stride_q),
        .a_addr   (a_addr),
        .b_addr   (b_addr)
    );

    // Data for the read issued at cnt n lands while cnt is n+1.
    assign wr_n = cnt[2:0] - 3'd1;
    assign wr_a = a_idx(wr_n[2], wr_n[1:0]);
    assign wr_b = b_idx(wr_n[1:0], wr_n[2]);
    assign rd   = (state == LOAD) && !cnt[3];

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (bus.start) nxt = LOAD;
            LOAD: if (cnt == 4'd8) nxt = RUN;
            RUN: begin
                if (bus.sa_done) begin
                    nxt = OUT;
                end else if (wd == TO_W'(TIMEOUT - 1)) begin
                    nxt = ERR;
                end
            end
            OUT:  if (bus.out_ready) nxt = IDLE;
            ERR:  nxt = ERR;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cnt        <= '0;
            wd         <= '0;
            a_base_q   <= '0;
            a_stride_q <= '0;
            b_base_q   <= '0;
            b_stride_q <= '0;
            cal_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            tile_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_base_q   <= bus.a_base;
                        a_stride_q <= bus.a_stride;
                        b_base_q   <= bus.b_base;
                        b_stride_q <= bus.b_stride;
                        cal_q      <= bus.cal_imp_in;
                        cnt        <= '0;
                        wd         <= '0;
                    end
                end
                LOAD: begin
                    cnt <= cnt + 4'd1;
                    if (cnt != 4'd0) begin
                        a_q[int'(wr_a)*WIDTH +: WIDTH] <= bus.a_rd_data;
                        b_q[int'(wr_b)*WIDTH +: WIDTH] <= bus.b_rd_data;
                    end
                end
                RUN: begin
                    wd <= wd + TO_W'(1);
                    if (bus.sa_done) tile_q <= bus.sa_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.a_rd_en     = rd;
    assign bus.b_rd_en     = rd;
    assign bus.a_rd_addr   = rd ? a_addr : '0;
    assign bus.b_rd_addr   = rd ? b_addr : '0;
    assign bus.sa_a        = a_q;
    assign bus.sa_b        = b_q;
    assign bus.sa_enable   = (state == RUN);
    assign bus.sa_cal_imp  = cal_q;
    assign bus.out_valid   = (state == OUT);
    assign bus.out_tile    = tile_q;
    assign bus.err         = (state == ERR);

endmodule

// File: tb/tb_sa_tile_loader.sv
// Directed bench for sa_tile_loader: buffer and array models plus vector table.
// Expected tiles, packings and address lists are hand-computed constants.
module tb_sa_tile_loader;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   hang;
    int   run_cnt;
    int   acc;

    logic [7:0] amem [1024];
    logic [7:0] bmem [1024];
    logic [9:0] aq [$];
    logic [9:0] bq [$];

    typedef struct {
        logic [9:0]  ab;
        logic [9:0]  as;
        logic [9:0]  bb;
        logic [9:0]  bs;
        logic        cal;
        logic [63:0] tile;
        logic [63:0] pa;
        logic [63:0] pb;
        logic [9:0]  aadr [8];
        logic [9:0]  badr [8];
    } vec_t;

    vec_t vt [4];

    sa_tile_loader_if #(.WIDTH(8), .ADDR_W(10)) bus ();

    sa_tile_loader #(
        .WIDTH   (8),
        .ADDR_W  (10),
        .TIMEOUT (15)
    ) dut (
        .clk    (clk),
        ._reset (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read buffers and address logging
    always @(posedge clk) begin
        if (bus.a_rd_en) begin
            bus.a_rd_data <= amem[bus.a_rd_addr];
            aq.push_back(bus.a_rd_addr);
        end
        if (bus.b_rd_en) begin
            bus.b_rd_data <= bmem[bus.b_rd_addr];
            bq.push_back(bus.b_rd_addr);
        end
    end

    // Array model: signed 2x4 * 4x2 product, done a few cycles into RUN
    always_comb begin
        acc = 0;
        bus.sa_result = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) begin
                    acc += int'($signed(bus.sa_a[(r*4+k)*8 +: 8]))
                         * int'($signed(bus.sa_b[(c*4+k)*8 +: 8]));
                end
                bus.sa_result[(r*2+c)*16 +: 16] = acc[15:0];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= 0;
            bus.sa_done <= 1'b0;
        end else begin
            run_cnt     <= bus.sa_enable ? run_cnt + 1 : 0;
            bus.sa_done <= bus.sa_enable && !hang && (run_cnt == 2);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [9:0] ab,
                           input logic [9:0] as, input logic [9:0] bb,
                           input logic [9:0] bs, input logic cal,
                           input logic [63:0] tile, input logic [63:0] pa,
                           input logic [63:0] pb);
        vt[i].ab   = ab;
        vt[i].as   = as;
        vt[i].bb   = bb;
        vt[i].bs   = bs;
        vt[i].cal  = cal;
        vt[i].tile = tile;
        vt[i].pa   = pa;
        vt[i].pb   = pb;
    endtask

    task automatic issue(input int i);
        aq.delete();
        bq.delete();
        @(negedge clk);
        chk("start_ready", 64'(bus.start_ready), 64'd1);
        bus.a_base     = vt[i].ab;
        bus.a_stride   = vt[i].as;
        bus.b_base     = vt[i].bb;
        bus.b_stride   = vt[i].bs;
        bus.cal_imp_in = vt[i].cal;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Disturb the request inputs; only the accepted values may be used
        bus.a_base     = ~vt[i].ab;
        bus.a_stride   = vt[i].as + 10'd3;
        bus.b_base     = vt[i].bb ^ 10'h155;
        bus.b_stride   = vt[i].bs + 10'd1;
        bus.cal_imp_in = ~vt[i].cal;
    endtask

    task automatic run_vec(input int i, input bit rdy);
        int n;
        issue(i);
        chk("first_read", 64'(bus.a_rd_en), 64'd1);
        n = 0;
        while (!bus.sa_enable && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("run_latency", 64'(n), 64'd9);
        chk("cal_imp_run", 64'(bus.sa_cal_imp), 64'(vt[i].cal));
        chk("sa_a_pack", bus.sa_a, vt[i].pa);
        chk("sa_b_pack", bus.sa_b, vt[i].pb);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("out_tile", bus.out_tile, vt[i].tile);
        chk("cal_imp_out", 64'(bus.sa_cal_imp), 64'(vt[i].cal));
        chk("a_reads", 64'(aq.size()), 64'd8);
        chk("b_reads", 64'(bq.size()), 64'd8);
        if (aq.size() == 8 && bq.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("a_addr%0d", j), 64'(aq[j]), 64'(vt[i].aadr[j]));
                chk($sformatf("b_addr%0d", j), 64'(bq[j]), 64'(vt[i].badr[j]));
            end
        end
        if (rdy) begin
            @(posedge clk);
            #1;
            chk("handshake", {62'd0, bus.out_valid, bus.start_ready}, 64'd1);
        end
    endtask

    initial begin
        int m;
        total = 0;
        bad   = 0;
        hang  = 1'b0;
        rst_n = 1'b0;
        bus.start      = 1'b0;
        bus.a_base     = '0;
        bus.a_stride   = '0;
        bus.b_base     = '0;
        bus.b_stride   = '0;
        bus.cal_imp_in = 1'b0;
        bus.out_ready  = 1'b1;
        bus.a_rd_data  = '0;
        bus.b_rd_data  = '0;
        for (int j = 0; j < 1024; j++) begin
            amem[j] = 8'd0;
            bmem[j] = 8'd0;
        end
        for (int j = 0; j < 8; j++) begin
            amem[j]      = 8'(j + 1);
            bmem[16 + j] = 8'(j + 1);
        end
        amem[1022] = 8'hFF;
        amem[1023] = 8'hFE;
        bmem[1020] = 8'd2;
        bmem[1021] = 8'hFD;
        bmem[1022] = 8'd4;
        bmem[1023] = 8'd1;
        for (int j = 0; j < 4; j++) bmem[j] = 8'd1;

        set_vec(0, 10'd0, 10'd4, 10'd16, 10'd2, 1'b0,
                64'h008C_0072_003C_0032,
                64'h0807060504030201, 64'h0806040207050301);
        vt[0].aadr = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
        vt[0].badr = '{10'd16, 10'd18, 10'd20, 10'd22,
                       10'd17, 10'd19, 10'd21, 10'd23};
        set_vec(1, 10'd1022, 10'd1, 10'd16, 10'd2, 1'b1,
                64'h0024_0020_000C_000C,
                64'h030201FE0201FEFF, 64'h0806040207050301);
        vt[1].aadr = '{10'd1022, 10'd1023, 10'd0, 10'd1,
                       10'd1023, 10'd0, 10'd1, 10'd2};
        vt[1].badr = vt[0].badr;
        set_vec(2, 10'd0, 10'd4, 10'd1020, 10'd2, 1'b0,
                64'h0006_0031_0006_0011,
                64'h0807060504030201, 64'h010101FD01010402);
        vt[2].aadr = vt[0].aadr;
        vt[2].badr = '{10'd1020, 10'd1022, 10'd0, 10'd2,
                       10'd1021, 10'd1023, 10'd1, 10'd3};
        set_vec(3, 10'd4, 10'd0, 10'd16, 10'd2, 1'b1,
                64'h008C_0072_008C_0072,
                64'h0807060508070605, 64'h0806040207050301);
        vt[3].aadr = '{10'd4, 10'd5, 10'd6, 10'd7, 10'd4, 10'd5, 10'd6, 10'd7};
        vt[3].badr = vt[0].badr;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_start_ready", 64'(bus.start_ready), 64'd1);
        chk("rst_outputs", {59'd0, bus.a_rd_en, bus.b_rd_en, bus.sa_enable,
                            bus.out_valid, bus.err}, 64'd0);
        chk("rst_tile", bus.out_tile, 64'd0);

        for (int i = 0; i < 4; i++) begin
            if (i != 2) run_vec(i, 1'b1);
        end

        // Result held while downstream stalls; starts in OUT are dropped
        bus.out_ready = 1'b0;
        run_vec(2, 1'b0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_tile", bus.out_tile, vt[2].tile);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", {62'd0, bus.out_valid, bus.start_ready}, 64'd1);
        @(posedge clk);
        #1;
        chk("no_queued_start", 64'(bus.a_rd_en), 64'd0);

        // Asynchronous reset in the middle of LOAD
        issue(0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(bus.start_ready), 64'd1);
        chk("midrst_outputs", {60'd0, bus.a_rd_en, bus.sa_enable,
                               bus.out_valid, bus.err}, 64'd0);
        chk("midrst_tile", bus.out_tile, 64'd0);
        chk("midrst_sa_a", bus.sa_a, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(1, 1'b1);

        // Watchdog: array never completes
        hang = 1'b1;
        issue(0);
        m = 0;
        while (!bus.sa_enable && m < 30) begin
            @(posedge clk);
            #1;
            m++;
        end
        m = 0;
        while (bus.sa_enable && m < 40) begin
            m++;
            @(posedge clk);
            #1;
        end
        chk("wd_run_cycles", 64'(m), 64'd15);
        chk("wd_err", 64'(bus.err), 64'd1);
        chk("wd_ready", 64'(bus.start_ready), 64'd0);
        @(negedge clk);
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", {61'd0, bus.err, bus.start_ready, bus.a_rd_en},
            64'd4);
        bus.start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
